// File: rtl/tank_input_mapper.sv
// Merges PS/2 keyboard events and MiSTer joysticks into registered per-player tank controls,
// with two-lever stick conversion, coin pulse shaping and optional autofire.
module tank_input_mapper #(
  parameter int NUM_PLAYERS  = 2,
  parameter int COIN_PULSE   = 120000,
  parameter int AUTOFIRE_DIV = 600000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joy,
  input  logic [NUM_PLAYERS-1:0]    tank_mode,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  output logic [4*NUM_PLAYERS-1:0]  lever_n,
  output logic [NUM_PLAYERS-1:0]    fire,
  output logic                      start1_n,
  output logic                      start2_n,
  output logic [1:0]                coin_n
);

  localparam int CNT_MAX = (COIN_PULSE > AUTOFIRE_DIV) ? COIN_PULSE : AUTOFIRE_DIV;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_state_t;

  // Latch index: 0-3 P1 U/D/L/R, 4 P1 fire, 5-8 P2 U/D/L/R, 9 P2 fire,
  // 10/11 start1 keys, 12/13 start2 keys, 14 coin1, 15 coin2, 16 both coins.
  function automatic logic [16:0] key_decode(input logic [8:0] code);
    key_decode = '0;
    case (code)
      9'h175:  key_decode[0]  = 1'b1;
      9'h172:  key_decode[1]  = 1'b1;
      9'h16B:  key_decode[2]  = 1'b1;
      9'h174:  key_decode[3]  = 1'b1;
      9'h014:  key_decode[4]  = 1'b1;
      9'h02D:  key_decode[5]  = 1'b1;
      9'h02B:  key_decode[6]  = 1'b1;
      9'h023:  key_decode[7]  = 1'b1;
      9'h034:  key_decode[8]  = 1'b1;
      9'h01C:  key_decode[9]  = 1'b1;
      9'h016:  key_decode[10] = 1'b1;
      9'h005:  key_decode[11] = 1'b1;
      9'h01E:  key_decode[12] = 1'b1;
      9'h006:  key_decode[13] = 1'b1;
      9'h02E:  key_decode[14] = 1'b1;
      9'h036:  key_decode[15] = 1'b1;
      9'h004:  key_decode[16] = 1'b1;
      default: key_decode     = '0;
    endcase
  endfunction

  // {U,D,L,R} -> {W_fw,W_bk,X_fw,X_bk}, active-high
  function automatic logic [3:0] tank_map(input logic [3:0] udlr);
    case (udlr)
      4'b1000: tank_map = 4'b1010;
      4'b1010: tank_map = 4'b0010;
      4'b1001: tank_map = 4'b1000;
      4'b0001: tank_map = 4'b1001;
      4'b0101: tank_map = 4'b0100;
      4'b0100: tank_map = 4'b0101;
      4'b0110: tank_map = 4'b0001;
      4'b0010: tank_map = 4'b0110;
      default: tank_map = 4'b0000;
    endcase
  endfunction

  logic        kb_armed;
  logic        tog_q;
  logic [10:0] ps2_q;
  logic [16:0] kb_q;
  logic [16:0] kb_hit;

  assign kb_hit = key_decode(ps2_q[8:0]);

  // The first edge after reset only captures the toggle level so a stale toggle is never an event.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      kb_armed <= 1'b0;
      tog_q    <= 1'b0;
      ps2_q    <= '0;
      kb_q     <= '0;
    end else if (!kb_armed) begin
      kb_armed <= 1'b1;
      tog_q    <= ps2_key[10];
      ps2_q    <= ps2_key;
    end else begin
      ps2_q <= ps2_key;
      if (ps2_q[10] != tog_q) begin
        tog_q <= ps2_q[10];
        kb_q  <= (kb_q & ~kb_hit) | (kb_hit & {17{ps2_q[9]}});
      end
    end
  end

  logic [4:0] pl_m [NUM_PLAYERS];
  logic       any_s1, any_s2, any_coin;
  logic [1:0] coin_m;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [4:0] kb_bits;
    logic       unused_joy_hi;
    if (p == 0) begin : g_kb_p1
      assign kb_bits = {kb_q[4], kb_q[0], kb_q[1], kb_q[2], kb_q[3]};
    end else if (p == 1) begin : g_kb_p2
      assign kb_bits = {kb_q[9], kb_q[5], kb_q[6], kb_q[7], kb_q[8]};
    end else begin : g_kb_none
      assign kb_bits = 5'b0;
    end
    assign pl_m[p]       = joy[16*p +: 5] | kb_bits;
    assign unused_joy_hi = ^joy[16*p+8 +: 8];
  end

  always_comb begin
    any_s1   = kb_q[10] | kb_q[11];
    any_s2   = kb_q[12] | kb_q[13];
    any_coin = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      any_s1   = any_s1   | joy[16*p+5];
      any_s2   = any_s2   | joy[16*p+6];
      any_coin = any_coin | joy[16*p+7];
    end
    coin_m[0] = any_coin | kb_q[14] | kb_q[16];
    coin_m[1] = any_coin | kb_q[15] | kb_q[16];
  end

  logic [CW-1:0] af_cnt;
  logic          af_phase;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == CW'(AUTOFIRE_DIV - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lever_n  <= '1;
      fire     <= '0;
      start1_n <= 1'b1;
      start2_n <= 1'b1;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        lever_n[4*p +: 4] <= tank_mode[p] ? ~tank_map(pl_m[p][3:0]) : ~pl_m[p][3:0];
        fire[p]           <= (autofire_en[p] && pl_m[p][4]) ? af_phase : pl_m[p][4];
      end
      start1_n <= ~any_s1;
      start2_n <= ~any_s2;
    end
  end

  // One pulse per press: the slot must see the coin released before it can fire again.
  for (genvar s = 0; s < 2; s++) begin : g_coin
    coin_state_t   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          out_n_q;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        st_q    <= C_IDLE;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        out_n_q <= 1'b1;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        prev_q  <= coin_m[s];
        out_n_q <= (st_d != C_PULSE);
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        C_IDLE: begin
          if (coin_m[s] && !prev_q) begin
            st_d  = C_PULSE;
            cnt_d = CW'(COIN_PULSE - 1);
          end
        end
        C_PULSE: begin
          if (cnt_q == '0) st_d = C_WAIT;
          else             cnt_d = cnt_q - CW'(1);
        end
        C_WAIT: begin
          if (!coin_m[s]) st_d = C_IDLE;
        end
        default: st_d = C_IDLE;
      endcase
    end

    assign coin_n[s] = out_n_q;
  end

endmodule
